// File: rtl/shift_pkg.sv
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and constants for the parametrised shift
//                register and its frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  // Operating mode of the stage array, sampled only while enabled.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_FWD  = 2'd1,
    MODE_REV  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_t;

  // Smallest stage count for which a shift register is meaningful.
  localparam int MIN_DEPTH = 2;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_frame_cnt.sv
// ============================================================================
//  Module      : shift_frame_cnt
//  Description : Wrap counter of shifts within a frame. Counts inc pulses
//                modulo DEPTH and emits a registered one-cycle wrap pulse on
//                the increment that returns the count to zero. clr restarts
//                the frame and suppresses the pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_frame_cnt #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  // Next count: clear wins over increment; the pulse is only raised by the
  // increment that completes a frame, so any other cycle drops it.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule : shift_frame_cnt

`default_nettype wire

// File: rtl/param_shift_reg.sv
// ============================================================================
//  Module      : param_shift_reg
//  Description : DEPTH-stage, WIDTH-bit bidirectional shift register with
//                parallel load/readout, clock enable, shift counter and
//                frame-complete pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_fwd,
  input  logic [WIDTH-1:0]       sin_rev,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_fwd,
  output logic [WIDTH-1:0]       sout_rev,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [CW-1:0]          shift_cnt,
  output logic                   frame_done
);

  if (DEPTH < MIN_DEPTH) begin : g_depth_check
    $error("param_shift_reg: DEPTH must be at least %0d", MIN_DEPTH);
  end

  mode_t            mode_w;
  logic             shift_w;
  logic             load_w;
  logic [WIDTH-1:0] stage_q [DEPTH];

  assign mode_w  = mode_t'(mode);
  assign shift_w = en && ((mode_w == MODE_FWD) || (mode_w == MODE_REV));
  assign load_w  = en && (mode_w == MODE_LOAD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_src;
    logic [WIDTH-1:0] rev_src;
    logic [WIDTH-1:0] stage_d;

    // Stage 0 is fed from the forward serial input, others from their lower neighbour.
    if (i == 0) begin : g_fwd_head
      assign fwd_src = sin_fwd;
    end else begin : g_fwd_chain
      assign fwd_src = stage_q[i-1];
    end

    // The last stage is fed from the reverse serial input, others from their upper neighbour.
    if (i == DEPTH - 1) begin : g_rev_head
      assign rev_src = sin_rev;
    end else begin : g_rev_chain
      assign rev_src = stage_q[i+1];
    end

    // Select this stage's next word from the active mode.
    always_comb begin
      stage_d = stage_q[i];
      if (en) begin
        case (mode_w)
          MODE_FWD:  stage_d = fwd_src;
          MODE_REV:  stage_d = rev_src;
          MODE_LOAD: stage_d = pin[i*WIDTH +: WIDTH];
          default:   stage_d = stage_q[i];
        endcase
      end
    end

    // Stage storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d;
      end
    end

    assign pout[i*WIDTH +: WIDTH] = stage_q[i];
  end

  assign sout_fwd = stage_q[DEPTH-1];
  assign sout_rev = stage_q[0];

  shift_frame_cnt #(
    .DEPTH (DEPTH)
  ) u_frame_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (shift_w),
    .clr_i  (load_w),
    .cnt_o  (shift_cnt),
    .wrap_o (frame_done)
  );

endmodule : param_shift_reg

`default_nettype wire

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised multi-lane shift register; next generation of the team's 1-bit, 4-stage serial-in/serial-out register.
- Generalised to DEPTH stages of WIDTH-bit words.
- Adds bidirectional shift, parallel load/readout, clock enable, a shift counter and a frame-complete pulse.
- Used as serialiser/deserialiser and delay line in datapath front-ends.

Parameters:
- WIDTH, 1, bits per stage (≥1)
- DEPTH, 4, number of stages (≥2)
- CW, $clog2(DEPTH), shift-counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable; 0 = full hold
- mode  in  2  0 HOLD, 1 FWD, 2 REV, 3 LOAD
- sin_fwd  in  WIDTH  word entering stage 0 on FWD
- sin_rev  in  WIDTH  word entering stage DEPTH-1 on REV
- pin  in  DEPTH*WIDTH  parallel load; stage i = pin[i*WIDTH +: WIDTH]
- sout_fwd  out  WIDTH  stage DEPTH-1
- sout_rev  out  WIDTH  stage 0
- pout  out  DEPTH*WIDTH  all stages, same packing as pin
- shift_cnt  out  CW  shifts since last LOAD/wrap
- frame_done  out  1  one-cycle pulse after DEPTH shifts

Behaviour:
- Reset (rst_n=0, async): all stages, shift_cnt, frame_done = 0 immediately. Release is synchronous to the next clk edge.
- All outputs are registered. sout_fwd, sout_rev and pout are direct stage views.
- en=0:
  - stages and shift_cnt hold
  - frame_done = 0 next cycle
- en=1, HOLD: stages and shift_cnt hold; frame_done = 0.
- en=1, FWD:
  - stage[0] ← sin_fwd
  - stage[i] ← stage[i-1] for i = 1..DEPTH-1
  - old stage[DEPTH-1] is discarded
- en=1, REV:
  - stage[DEPTH-1] ← sin_rev
  - stage[i] ← stage[i+1] for i = 0..DEPTH-2
- en=1, LOAD:
  - stage[i] ← pin slice i
  - shift_cnt ← 0
  - frame_done ← 0
- Latency: a word presented on sin_fwd with FWD appears on sout_fwd after exactly DEPTH enabled FWD edges. REV is symmetric.
- Counter rules:
  - each enabled FWD or REV edge increments shift_cnt; direction does not matter
  - when shift_cnt == DEPTH-1 and a shift occurs: shift_cnt ← 0 and frame_done ← 1 for that cycle only
  - otherwise frame_done ← 0
- Direction change mid-frame does not reset the counter; it keeps counting total shifts.
- Reset mid-frame: counter and data are lost; no frame_done is generated.
- With DEPTH=4, WIDTH=1, en=1, mode=FWD held, the block is bit-exact equivalent to the existing 4-stage SISO, plus reset.

Decomposition:
- Shared package shift_pkg holds:
  - typedef mode_t (2-bit enum: MODE_HOLD=0, MODE_FWD=1, MODE_REV=2, MODE_LOAD=3)
  - constant MIN_DEPTH=2
- One sub-module, shift_frame_cnt: CW-bit wrap counter with inc/clr inputs and a registered wrap pulse. It provides shift_cnt and frame_done.
- The stage array is a generate loop in the top module.

Test Plan (WIDTH=8, DEPTH=4):
- Reset: drive rst_n=0 mid-cycle with stages non-zero -> pout=0, shift_cnt=0, frame_done=0 before the next clk edge.
- FWD fill:
  - stimulus: en=1, mode=FWD, sin_fwd = 0xA1, 0xB2, 0xC3, 0xD4 on four edges
  - pout = {0xA1,0xB2,0xC3,0xD4} (stage3..0)
  - sout_fwd = 0xA1
  - frame_done=1 for exactly the cycle after the 4th edge
  - shift_cnt=0
- LOAD then REV:
  - stimulus: load pin = stage0..3 = 0x11, 0x22, 0x33, 0x44; then one REV edge with sin_rev=0x55
  - stage0..3 = 0x22, 0x33, 0x44, 0x55
  - sout_rev = 0x22
  - shift_cnt = 1
- Enable gating:
  - stimulus: after 2 FWD shifts, en=0 for 3 cycles with mode=FWD, then 2 more FWD shifts
  - stages frozen during en=0; shift_cnt holds at 2
  - frame_done pulses only after the 4th real shift
- Mixed direction / LOAD abort:
  - FWD, REV, FWD, REV -> frame_done pulse after the 4th shift
  - separately: 3 shifts then LOAD -> shift_cnt=0 and no frame_done
- Reset mid-frame: 3 FWD shifts, pulse rst_n low, then 1 FWD shift -> shift_cnt=1, no frame_done, stage0 = new sin_fwd, other stages 0.
